cpu_bus_arb: RTL

CPU_BUS_ARB -- requirements
Module: cpu_bus_arb

---
 rtl/cpu_bus_arb_if.sv | 36 +++
 rtl/cpu_bus_arb.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arb_if.sv
// rtl/cpu_bus_arb_if.sv - channel and bus signal bundle for cpu_bus_arb
interface cpu_bus_arb_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_rw;
    logic [NCH*ADDR_W-1:0] ch_addr;
    logic [NCH*DATA_W-1:0] ch_wr_data;
    logic [NCH*DATA_W-1:0] ch_rd_data;
    logic [NCH-1:0]        ch_busy;
    logic [NCH-1:0]        ch_done;
    logic [NCH-1:0]        ch_err;
    logic                  bus_req_;
    logic                  bus_as_;
    logic                  bus_grnt_;
    logic                  bus_rdy_;
    logic [ADDR_W-1:0]     bus_addr;
    logic                  bus_rw;
    logic [DATA_W-1:0]     bus_wr_data;
    logic [DATA_W-1:0]     bus_rd_data;

    // master is the arbiter's view; slave is the pipeline channels plus the bus
    modport master (
        input  ch_req, ch_rw, ch_addr, ch_wr_data, bus_grnt_, bus_rdy_, bus_rd_data,
        output ch_rd_data, ch_busy, ch_done, ch_err,
        output bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data
    );

    modport slave (
        output ch_req, ch_rw, ch_addr, ch_wr_data, bus_grnt_, bus_rdy_, bus_rd_data,
        input  ch_rd_data, ch_busy, ch_done, ch_err,
        input  bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data
    );
endinterface

// File: rtl/cpu_bus_arb.sv
// rtl/cpu_bus_arb.sv - round-robin arbiter of CPU pipeline channels onto one external bus
module cpu_bus_arb #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    cpu_bus_arb_if.master arb_io
);
    localparam int          OWN_W   = $clog2(NCH);
    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACCESS, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [OWN_W-1:0]      ptr_q, ptr_d;
    logic [OWN_W-1:0]      owner_q, owner_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  rw_q, rw_d;
    logic                  req_n_q, req_n_d;
    logic                  as_n_q, as_n_d;
    logic                  to_q, to_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [NCH*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NCH-1:0]        done_q, done_d;
    logic [NCH-1:0]        err_q, err_d;
    logic                  win_found;
    logic [OWN_W-1:0]      win_idx;

    // A channel whose done pulse is still high is skipped so it cannot win twice in a row
    always_comb begin
        logic [OWN_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = OWN_W'((int'(ptr_q) + k) % NCH);
            if (!win_found && arb_io.ch_req[cand] && !done_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        req_n_d   = req_n_q;
        as_n_d    = 1'b1;
        to_d      = to_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        done_d    = '0;
        err_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    addr_d  = arb_io.ch_addr[win_idx*ADDR_W +: ADDR_W];
                    wdata_d = arb_io.ch_wr_data[win_idx*DATA_W +: DATA_W];
                    rw_d    = arb_io.ch_rw[win_idx];
                    req_n_d = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!arb_io.ch_req[owner_q]) begin
                    req_n_d = 1'b1;
                    rw_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (!arb_io.bus_grnt_) begin
                    as_n_d  = 1'b0;
                    cnt_d   = 16'd1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Counter already holds 1 for the strobe cycle, so it tracks cycles since grant
                cnt_d = cnt_q + 16'd1;
                if (!arb_io.bus_rdy_) begin
                    if (rw_q) begin
                        rd_data_d[owner_q*DATA_W +: DATA_W] = arb_io.bus_rd_data;
                    end
                    state_d = S_DONE;
                end else if (cnt_q >= TO_LAST) begin
                    if (rw_q) begin
                        rd_data_d[owner_q*DATA_W +: DATA_W] = '0;
                    end
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d[owner_q] = 1'b1;
                err_d[owner_q]  = to_q;
                req_n_d         = 1'b1;
                rw_d            = 1'b1;
                ptr_d           = owner_q;
                cnt_d           = '0;
                to_d            = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ptr_q     <= OWN_W'(NCH - 1);
            owner_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b1;
            req_n_q   <= 1'b1;
            as_n_q    <= 1'b1;
            to_q      <= 1'b0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            req_n_q   <= req_n_d;
            as_n_q    <= as_n_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign arb_io.ch_busy     = arb_io.ch_req & ~done_q;
    assign arb_io.ch_done     = done_q;
    assign arb_io.ch_err      = err_q;
    assign arb_io.ch_rd_data  = rd_data_q;
    assign arb_io.bus_req_    = req_n_q;
    assign arb_io.bus_as_     = as_n_q;
    assign arb_io.bus_addr    = addr_q;
    assign arb_io.bus_rw      = rw_q;
    assign arb_io.bus_wr_data = wdata_q;
endmodule
